lz_normalise_ctrl: RTL and testbench
====================================

Name: lz_normalise_ctrl

Overview:
- Multi-cycle normaliser controller for floating-point mantissas.
- Scans a WIDTH-bit operand CHUNK bits per cycle using a narrow leading-zero detector, then left-shifts the operand so its MSB is 1 and reports the shift count.
- Trades latency for area: one narrow leading-zero stage plus a shift register, instead of a full-width priority encoder and barrel shifter.
- Sits between the adder/multiplier result stage and the rounding/pack stage. Uses stb/ack handshakes on both sides.

Parameters:
- WIDTH, 24, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits examined per SCAN cycle; must be at least 2.
- COUNT_WIDTH, 5, width of out_count; must be at least clog2(WIDTH+1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  WIDTH  operand to normalise.
- in_stb  input  1  in_data valid.
- in_ack  output  1  ready to accept; registered.
- out_data  output  WIDTH  normalised operand.
- out_count  output  COUNT_WIDTH  number of leading zeros removed.
- out_zero  output  1  operand was all zero.
- out_stb  output  1  result valid; registered.
- out_ack  input  1  downstream has taken the result.

Behaviour:
- Handshake rule: a transfer occurs on a rising edge where stb and ack are both sampled high.
- Reset (async, any time, including mid-scan):
  - State goes to IDLE; the in-flight operand is discarded and no output is produced.
  - in_ack=0, out_stb=0, out_data=0, out_count=0, out_zero=0.
  - in_ack rises on the first clk edge after rst deasserts.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ack=1.
  - On transfer: shift register <= in_data, count <= 0, in_ack <= 0, go SCAN.
  - in_data is ignored whenever in_ack is low.
- SCAN (one cycle per chunk), examining the top CHUNK bits of the shift register:
  - Top chunk all zero and count+CHUNK < WIDTH: register <<= CHUNK, count += CHUNK, stay in SCAN.
  - Top chunk all zero and count+CHUNK == WIDTH: out_data=0, out_count=WIDTH, out_zero=1, go DONE.
  - Top chunk non-zero: let k = leading zeros within the chunk (0..CHUNK-1). out_data = register << k, out_count = count+k, out_zero=0, go DONE.
  - All outputs are registered on the transition into DONE; out_stb <= 1 on the same edge.
- Latency:
  - Input accepted at edge T; out_stb rises at edge T+n.
  - n = (number of leading all-zero chunks) + 1, capped at WIDTH/CHUNK.
  - Zero operand gives n = WIDTH/CHUNK.
- DONE:
  - out_stb=1; out_data, out_count and out_zero are held stable until the handshake.
  - On the edge where out_ack is sampled high: out_stb <= 0, in_ack <= 1, go IDLE.
  - Back-to-back throughput is therefore one operand per n+2 cycles minimum.
  - out_ack while out_stb=0 has no effect.
- Output validity: out_data MSB is 1 whenever out_zero=0. out_count never exceeds WIDTH.
- Arithmetic: count is an unsigned COUNT_WIDTH accumulator, no wrap (bounded by WIDTH). Shifts are logical; zeros fill from the LSB.
- in_stb held high across a result does not cause a double accept: the next accept requires in_ack high, i.e. after the out_ack handshake.

Test Plan:
- Reset check: assert rst mid-SCAN with in_data=0x000001 -> all outputs 0 immediately; no out_stb after release; in_ack=1 one edge after release.
- Already normalised: in_data=0x800000 -> out_stb 1 cycle after accept; out_data=0x800000, out_count=0, out_zero=0.
- Partial chunk: in_data=0x000123 -> out_stb 4 cycles after accept; out_data=0x918000, out_count=15.
- Chunk boundary: in_data=0x0F0000 -> n=2; out_data=0xF00000, out_count=4.
- Extremes:
  - in_data=0x000001 -> n=6; out_data=0x800000, out_count=23.
  - in_data=0 -> n=6; out_data=0, out_count=24, out_zero=1.
- Backpressure: hold out_ack=0 for 10 cycles with in_stb=1 and a new operand waiting -> out_* stable, in_ack stays 0. Pulse out_ack -> out_stb falls and in_ack rises on the same edge; the next operand is accepted on the following edge.

Source files
------------

// File: rtl/lz_normalise_ctrl.sv
// Multi-cycle mantissa normaliser: scans CHUNK bits per cycle with a narrow
// leading-zero detector, then reports the normalised operand and shift count.
module lz_normalise_ctrl #(
   parameter int unsigned WIDTH       = 24,
   parameter int unsigned CHUNK       = 4,
   parameter int unsigned COUNT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_stb,
   output logic                   in_ack,
   output logic [WIDTH-1:0]       out_data,
   output logic [COUNT_WIDTH-1:0] out_count,
   output logic                   out_zero,
   output logic                   out_stb,
   input  logic                   out_ack
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                 state, state_n;
   logic [WIDTH-1:0]       sreg, sreg_n;
   logic [COUNT_WIDTH-1:0] count, count_n;
   logic [WIDTH-1:0]       out_data_n;
   logic [COUNT_WIDTH-1:0] out_count_n;
   logic                   out_zero_n;
   logic                   out_stb_n;
   logic                   in_ack_n;

   logic [CHUNK-1:0]       top;
   logic [COUNT_WIDTH-1:0] lz_k;
   logic                   lz_found;
   logic                   top_zero;
   logic                   last_chunk;
   logic                   accept;

   assign top        = sreg[WIDTH-1 -: CHUNK];
   assign top_zero   = (top == '0);
   assign last_chunk = (count == COUNT_WIDTH'(WIDTH - CHUNK));
   assign accept     = in_ack && in_stb;

   // Leading zeros within the top chunk (only meaningful when it is non-zero)
   always_comb begin
      lz_k     = '0;
      lz_found = 1'b0;
      for (int i = 0; i < int'(CHUNK); i++) begin
         if (!lz_found && top[CHUNK-1-i]) begin
            lz_k     = COUNT_WIDTH'(i);
            lz_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = SCAN;
         SCAN:    if (!top_zero || last_chunk) state_n = DONE;
         DONE:    if (out_ack) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Next values for the datapath and registered outputs
   always_comb begin
      sreg_n      = sreg;
      count_n     = count;
      out_data_n  = out_data;
      out_count_n = out_count;
      out_zero_n  = out_zero;
      out_stb_n   = out_stb;
      in_ack_n    = in_ack;
      case (state)
         IDLE: begin
            in_ack_n = 1'b1;
            if (accept) begin
               sreg_n   = in_data;
               count_n  = '0;
               in_ack_n = 1'b0;
            end
         end
         SCAN: begin
            if (top_zero && !last_chunk) begin
               sreg_n  = sreg << CHUNK;
               count_n = count + COUNT_WIDTH'(CHUNK);
            end else if (top_zero) begin
               out_data_n  = '0;
               out_count_n = COUNT_WIDTH'(WIDTH);
               out_zero_n  = 1'b1;
               out_stb_n   = 1'b1;
            end else begin
               out_data_n  = sreg << lz_k;
               out_count_n = count + lz_k;
               out_zero_n  = 1'b0;
               out_stb_n   = 1'b1;
            end
         end
         DONE: begin
            if (out_ack) begin
               out_stb_n = 1'b0;
               in_ack_n  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg      <= '0;
         count     <= '0;
         out_data  <= '0;
         out_count <= '0;
         out_zero  <= 1'b0;
         out_stb   <= 1'b0;
         in_ack    <= 1'b0;
      end else begin
         sreg      <= sreg_n;
         count     <= count_n;
         out_data  <= out_data_n;
         out_count <= out_count_n;
         out_zero  <= out_zero_n;
         out_stb   <= out_stb_n;
         in_ack    <= in_ack_n;
      end
   end

endmodule

// File: tb/tb_lz_normalise_ctrl.sv
// Bench for lz_normalise_ctrl: directed vector table, reset/backpressure
// sequences and randomized operands against a leading-zero-count model.
module tb_lz_normalise_ctrl;

   localparam int unsigned W  = 24;
   localparam int unsigned C  = 4;
   localparam int unsigned CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  in_data;
   logic          in_stb;
   logic          in_ack;
   logic [W-1:0]  out_data;
   logic [CW-1:0] out_count;
   logic          out_zero;
   logic          out_stb;
   logic          out_ack;

   int total = 0;
   int bad   = 0;

   lz_normalise_ctrl #(.WIDTH(W), .CHUNK(C), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
      .out_data(out_data), .out_count(out_count), .out_zero(out_zero),
      .out_stb(out_stb), .out_ack(out_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic [W-1:0] exp_data;
      int           exp_count;
      logic         exp_zero;
      int           exp_n;
   } vec_t;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: count leading zeros bit by bit, derive everything from that
   task automatic model(input logic [W-1:0] d, output logic [W-1:0] md,
                        output int mc, output logic mz, output int mn);
      int lz = 0;
      while (lz < int'(W) && d[W-1-lz] == 1'b0) lz++;
      mz = (lz == int'(W));
      mc = lz;
      md = mz ? '0 : W'(d << lz);
      mn = mz ? int'(W / C) : (lz / int'(C)) + 1;
   endtask

   // Present operand until accepted; returns at the negedge after the accept edge
   task automatic start_op(input logic [W-1:0] d);
      int waited = 0;
      in_data = d;
      in_stb  = 1'b1;
      while (!in_ack && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ack) chk("accept_timeout", 0, 1);
      @(negedge clk);
      in_stb  = 1'b0;
      in_data = $urandom;
   endtask

   // Called at the negedge after the accept edge; checks latency and result
   task automatic wait_result(input string tag, input logic [W-1:0] ed,
                              input int ec, input logic ez, input int en);
      int lat = 0;
      chk({tag, "_in_ack_low"}, in_ack, 0);
      do begin
         @(negedge clk);
         lat++;
      end while (!out_stb && lat < 50);
      chk({tag, "_latency"}, lat, en);
      chk({tag, "_data"}, out_data, ed);
      chk({tag, "_count"}, out_count, ec);
      chk({tag, "_zero"}, out_zero, ez);
   endtask

   task automatic ack_result(input string tag, input int delay);
      repeat (delay) @(negedge clk);
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      chk({tag, "_stb_drop"}, out_stb, 0);
      chk({tag, "_in_ack_rise"}, in_ack, 1);
   endtask

   vec_t vecs[5];

   initial begin
      logic [W-1:0] md;
      int mc, mn, stb_seen;
      logic mz;

      vecs[0] = '{24'h800000, 24'h800000, 0,  1'b0, 1};
      vecs[1] = '{24'h000123, 24'h918000, 15, 1'b0, 4};
      vecs[2] = '{24'h0F0000, 24'hF00000, 4,  1'b0, 2};
      vecs[3] = '{24'h000001, 24'h800000, 23, 1'b0, 6};
      vecs[4] = '{24'h000000, 24'h000000, 24, 1'b1, 6};

      rst = 1'b1; in_data = '0; in_stb = 1'b0; out_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ack", in_ack, 0);
      chk("rst_out_stb", out_stb, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ack", in_ack, 1);

      for (int i = 0; i < 5; i++) begin
         start_op(vecs[i].data);
         wait_result($sformatf("vec%0d", i), vecs[i].exp_data,
                     vecs[i].exp_count, vecs[i].exp_zero, vecs[i].exp_n);
         ack_result($sformatf("vec%0d", i), i % 2);
      end

      // Reset in the middle of a scan
      start_op(24'h000001);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_data", out_data, 0);
      chk("midrst_count", out_count, 0);
      chk("midrst_zero", out_zero, 0);
      chk("midrst_stb", out_stb, 0);
      chk("midrst_in_ack", in_ack, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_release_in_ack", in_ack, 0);
      @(negedge clk);
      chk("midrst_in_ack_one_edge", in_ack, 1);
      stb_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_stb) stb_seen++;
      end
      chk("midrst_no_stb", stb_seen, 0);

      // Backpressure with a second operand waiting
      start_op(24'h000123);
      wait_result("bp1", 24'h918000, 15, 1'b0, 4);
      in_data = 24'h0F0000;
      in_stb  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("bp_hold%0d_data", c), out_data, 24'h918000);
         chk($sformatf("bp_hold%0d_count", c), out_count, 15);
         chk($sformatf("bp_hold%0d_stb", c), out_stb, 1);
         chk($sformatf("bp_hold%0d_in_ack", c), in_ack, 0);
      end
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      chk("bp_stb_drop", out_stb, 0);
      chk("bp_in_ack_rise", in_ack, 1);
      @(negedge clk);
      in_stb = 1'b0;
      wait_result("bp2", 24'hF00000, 4, 1'b0, 2);
      ack_result("bp2", 0);

      // Randomized operands with spread of leading-zero counts
      for (int r = 0; r < 40; r++) begin
         logic [W-1:0] d;
         d = W'($urandom) >> $urandom_range(0, W);
         model(d, md, mc, mz, mn);
         start_op(d);
         wait_result($sformatf("rnd%0d", r), md, mc, mz, mn);
         ack_result($sformatf("rnd%0d", r), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
